// File: rtl/led_mode_ctrl.sv
// Push-button LED mode sequencer: synchroniser, debouncer, 4-mode FSM and paced blink/chase patterns.
// Optional long-press-to-OFF feature is enabled by defining LEDCTRL_LONGPRESS_EN.
module led_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYC  = 4,
    parameter int unsigned TICK_DIV      = 8,
    parameter int unsigned LONGPRESS_CYC = 32
) (
    input  logic       i_SCLK,
    input  logic       i_RESET_SYSB,
    input  logic       i_PMOD1_P1,
    output logic [3:0] o_LED,
    output logic [1:0] o_MODE,
    output logic       o_PRESS
);

    localparam int unsigned DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned TK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_CHASE = 2'd3
    } mode_e;

    logic            sync1_q;
    logic            sync2_q;
    logic            stable_q;
    logic            stable_d;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic [TK_W-1:0] tick_cnt_q;
    logic [TK_W-1:0] tick_cnt_d;
    logic            press_s;
    logic            tick_s;
    logic            long_s;
    mode_e           mode_q;
    logic [3:0]      led_q;
    logic            press_q;

    // Elaboration-time guard against unusable parameter values.
    if ((DEBOUNCE_CYC < 2) || (TICK_DIV < 2) || (LONGPRESS_CYC < 1)) begin : g_bad_params
        $error("led_mode_ctrl: invalid parameter values");
    end

    // Debounce next-state: the stable level only moves after DEBOUNCE_CYC consecutive mismatches.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        if (sync2_q == stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            stable_d = sync2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // A press is the falling transition of the debounced level; release produces nothing.
    assign press_s = stable_q & ~stable_d;
    assign tick_s  = (tick_cnt_q == TK_LAST);

    // Tick prescaler next-state; a mode change restarts the pattern period.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (press_s || long_s) begin
            tick_cnt_d = '0;
        end else if (tick_s) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TK_W'(1);
        end
    end

`ifdef LEDCTRL_LONGPRESS_EN
    localparam int unsigned HD_W = $clog2(LONGPRESS_CYC + 1);
    localparam logic [HD_W-1:0] HD_MAX = HD_W'(LONGPRESS_CYC);

    logic [HD_W-1:0] hold_q;
    logic [HD_W-1:0] hold_d;

    // Hold counter saturates at the threshold so the forced OFF fires once per hold.
    always_comb begin
        hold_d = hold_q;
        if (stable_q) begin
            hold_d = '0;
        end else if (hold_q != HD_MAX) begin
            hold_d = hold_q + HD_W'(1);
        end else begin
            hold_d = hold_q;
        end
    end

    assign long_s = ~stable_q & (hold_q == (HD_MAX - HD_W'(1)));

    // Hold counter register.
    always_ff @(posedge i_SCLK) begin
        if (!i_RESET_SYSB) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign long_s = 1'b0;
`endif

    // Input synchroniser, debounce state and tick prescaler registers.
    always_ff @(posedge i_SCLK) begin
        if (!i_RESET_SYSB) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            stable_q   <= 1'b1;
            db_cnt_q   <= '0;
            tick_cnt_q <= '0;
        end else begin
            sync1_q    <= i_PMOD1_P1;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            db_cnt_q   <= db_cnt_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Mode FSM with registered LED pattern and press pulse; a press outranks a same-cycle tick.
    always_ff @(posedge i_SCLK) begin
        if (!i_RESET_SYSB) begin
            mode_q  <= MODE_OFF;
            led_q   <= 4'b0000;
            press_q <= 1'b0;
        end else begin
            press_q <= press_s;
            if (press_s) begin
                case (mode_q)
                    MODE_OFF: begin
                        mode_q <= MODE_ON;
                        led_q  <= 4'b1111;
                    end
                    MODE_ON: begin
                        mode_q <= MODE_BLINK;
                        led_q  <= 4'b1111;
                    end
                    MODE_BLINK: begin
                        mode_q <= MODE_CHASE;
                        led_q  <= 4'b0001;
                    end
                    MODE_CHASE: begin
                        mode_q <= MODE_OFF;
                        led_q  <= 4'b0000;
                    end
                    default: begin
                        mode_q <= MODE_OFF;
                        led_q  <= 4'b0000;
                    end
                endcase
            end else if (long_s) begin
                mode_q <= MODE_OFF;
                led_q  <= 4'b0000;
            end else if (tick_s) begin
                case (mode_q)
                    MODE_BLINK: led_q <= ~led_q;
                    MODE_CHASE: led_q <= {led_q[2:0], led_q[3]};
                    default:    led_q <= led_q;
                endcase
            end else begin
                led_q <= led_q;
            end
        end
    end

    assign o_LED   = led_q;
    assign o_MODE  = mode_q;
    assign o_PRESS = press_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed self-checking bench for led_mode_ctrl at default parameters.
// Expected long-press behaviour follows whether LEDCTRL_LONGPRESS_EN is defined.
module tb_led_mode_ctrl;

`ifdef LEDCTRL_LONGPRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic [3:0] led;
    logic [1:0] mode;
    logic       press;

    int tests     = 0;
    int fails     = 0;
    int press_cnt = 0;
    int base      = 0;

    always #5 clk = ~clk;

    led_mode_ctrl #(
        .DEBOUNCE_CYC (4),
        .TICK_DIV     (8),
        .LONGPRESS_CYC(32)
    ) dut (
        .i_SCLK      (clk),
        .i_RESET_SYSB(rst_n),
        .i_PMOD1_P1  (btn),
        .o_LED       (led),
        .o_MODE      (mode),
        .o_PRESS     (press)
    );

    // Advance n falling edges, tallying every observed press pulse.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (press === 1'b1) press_cnt++;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 13-cycle low press: checks latency, one-cycle pulse and entry pattern; returns 7 edges after the event.
    task automatic do_press(input string tag, input int exp_mode, input int exp_led);
        btn = 1'b0;
        step(5);
        chk({tag, "_pre"}, int'(press), 0);
        step(1);
        chk({tag, "_press"}, int'(press), 1);
        chk({tag, "_mode"}, int'(mode), exp_mode);
        chk({tag, "_led"}, int'(led), exp_led);
        step(1);
        chk({tag, "_pulse_end"}, int'(press), 0);
        step(6);
        btn = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 1'b1;
        step(2);
        chk("rst_led", int'(led), 0);
        chk("rst_mode", int'(mode), 0);
        chk("rst_press", int'(press), 0);

        rst_n = 1'b1;
        step(20);
        chk("idle_led", int'(led), 0);
        chk("idle_mode", int'(mode), 0);
        chk("idle_press_cnt", press_cnt, 0);

        btn = 1'b0; step(3); btn = 1'b1; step(10);
        chk("glitch_cnt", press_cnt, 0);
        chk("glitch_mode", int'(mode), 0);

        btn = 1'b0; step(3); btn = 1'b1; step(1);
        btn = 1'b0; step(3); btn = 1'b1; step(10);
        chk("gap_cnt", press_cnt, 0);

        do_press("p1", 1, 4'hF);
        step(12);
        chk("on_steady_led", int'(led), 4'hF);

        do_press("p2", 2, 4'hF);
        chk("blink_n7", int'(led), 4'hF);
        step(1);
        chk("blink_n8", int'(led), 4'h0);
        step(8);
        chk("blink_n16", int'(led), 4'hF);
        step(2);

        // This press lands exactly on the third blink tick edge.
        do_press("p3", 3, 4'h1);
        chk("chase_n7", int'(led), 4'h1);
        step(1);
        chk("chase_n8", int'(led), 4'h2);
        step(8);
        chk("chase_n16", int'(led), 4'h4);
        step(8);
        chk("chase_n24", int'(led), 4'h8);
        step(7);
        chk("chase_n31", int'(led), 4'h8);
        step(1);
        chk("chase_n32", int'(led), 4'h1);
        step(8);
        chk("chase_n40", int'(led), 4'h2);

        do_press("p4", 0, 4'h0);
        step(12);
        chk("off_led", int'(led), 4'h0);
        chk("four_press_cnt", press_cnt, 4);

        do_press("r1", 1, 4'hF);
        step(12);
        do_press("r2", 2, 4'hF);
        step(3);
        rst_n = 1'b0;
        btn   = 1'b0;
        step(1);
        chk("midrst_led", int'(led), 0);
        chk("midrst_mode", int'(mode), 0);
        chk("midrst_press", int'(press), 0);
        base  = press_cnt;
        rst_n = 1'b1;
        step(5);
        chk("held_pre", int'(press), 0);
        step(1);
        chk("held_press", int'(press), 1);
        chk("held_mode", int'(mode), 1);
        chk("held_led", int'(led), 4'hF);
        step(10);
        btn = 1'b1;
        step(12);
        chk("held_one_press", press_cnt - base, 1);

        rst_n = 1'b0; step(1); rst_n = 1'b1; step(3);
        base = press_cnt;
        btn  = 1'b0;
        step(6);
        chk("lp_mode_press", int'(mode), 1);
        step(31);
        chk("lp_n31_mode", int'(mode), 1);
        chk("lp_n31_led", int'(led), 4'hF);
        step(1);
        chk("lp_n32_mode", int'(mode), LP_EN ? 0 : 1);
        chk("lp_n32_led", int'(led), LP_EN ? 4'h0 : 4'hF);
        step(12);
        chk("lp_hold_mode", int'(mode), LP_EN ? 0 : 1);
        btn = 1'b1;
        step(12);
        chk("lp_press_cnt", press_cnt - base, 1);
        chk("lp_release_mode", int'(mode), LP_EN ? 0 : 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
